// File: rtl/xyolo_wr_pack_pkg.sv
// Shared types and helpers for the xyolo write-back packer.
package xyolo_wr_pack_pkg;

   // Packer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Number of bytes covered by a field of the given bit width
   function automatic int bytes_of(input int bits);
      return bits / 8;
   endfunction

endpackage

// File: rtl/xyolo_wr_fifo.sv
// Small first-word-fall-through FIFO holding packed write requests.
// The head entry is presented on pop_data whenever the FIFO is not empty;
// an empty FIFO presents all zeros so downstream fields read 0 after reset.
module xyolo_wr_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (PTR_W + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal only when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/xyolo_wr_pack.sv
// Write-back packer: gathers result elements into memory words, assigns
// incrementing byte addresses and queues the words for the memory write port.
module xyolo_wr_pack
   import xyolo_wr_pack_pkg::*;
#(
   parameter int DATAPATH_W = 16,
   parameter int MEM_DATA_W = 256,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 20,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [CNT_W-1:0]        n_elems,
   output logic                    busy,
   output logic                    done,
   output logic                    ovf,
   input  logic                    in_valid,
   input  logic [DATAPATH_W-1:0]   in_data,
   output logic                    in_ready,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [ADDR_W-1:0]       m_addr,
   output logic [MEM_DATA_W-1:0]   m_data,
   output logic [MEM_DATA_W/8-1:0] m_strb
);
   localparam int PACK   = MEM_DATA_W / DATAPATH_W;
   localparam int STRB_W = bytes_of(MEM_DATA_W);
   localparam int LANE_B = bytes_of(DATAPATH_W);
   localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int FIFO_W = ADDR_W + MEM_DATA_W + STRB_W;
   localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STRB_W);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PACK - 1);

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [CNT_W-1:0]       n_q, n_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   ovf_q, ovf_d;
   logic                   done_q, done_d;
   logic [DATAPATH_W-1:0]  lane_q [PACK];
   logic [DATAPATH_W-1:0]  lane_d [PACK];

   logic                   accept;
   logic                   last_elem;
   logic                   push_word;
   logic [MEM_DATA_W-1:0]  word_data;
   logic [STRB_W-1:0]      word_strb;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [FIFO_W-1:0]      fifo_in;
   logic [FIFO_W-1:0]      fifo_out;

   assign in_ready  = (state_q == ST_PACK) && !fifo_full;
   assign accept    = in_valid && in_ready;
   assign last_elem = (cnt_q == (n_q - CNT_W'(1)));
   // A word leaves the lane registers when its top lane fills or the run ends
   assign push_word = accept && ((idx_q == IDX_LAST) || last_elem);

   // Per-lane assembly: held lanes below idx, the incoming element at idx,
   // zero above idx with matching byte enables cleared
   for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign word_data[gi*DATAPATH_W +: DATAPATH_W] =
         (IDX_W'(gi) < idx_q)  ? lane_q[gi] :
         (IDX_W'(gi) == idx_q) ? in_data    : '0;
      assign word_strb[gi*LANE_B +: LANE_B] =
         (IDX_W'(gi) <= idx_q) ? {LANE_B{1'b1}} : {LANE_B{1'b0}};
      assign lane_d[gi] = (accept && (idx_q == IDX_W'(gi))) ? in_data : lane_q[gi];

      // Lane holding register
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            lane_q[gi] <= '0;
         end else begin
            lane_q[gi] <= lane_d[gi];
         end
      end
   end

   // Control FSM next state, counters and sticky overflow
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      ovf_d   = ovf_q;
      done_d  = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               addr_d  = base_addr;
               n_d     = n_elems;
               cnt_d   = '0;
               idx_d   = '0;
               ovf_d   = 1'b0;
               state_d = (n_elems == '0) ? ST_DONE : ST_PACK;
            end
         end
         ST_PACK: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
               idx_d = push_word ? '0 : idx_q + IDX_W'(1);
               if (push_word) begin
                  addr_d = addr_q + ADDR_INC;
               end
               if (push_word && last_elem) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Empty FIFO means no write request is still pending
            if (fifo_empty) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Elements offered while not accepted are dropped and flagged
      if ((state_q != ST_IDLE) && in_valid && !in_ready) begin
         ovf_d = 1'b1;
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign fifo_in  = {addr_q, word_data, word_strb};
   assign fifo_pop = m_valid && m_ready;

   xyolo_wr_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_word),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign m_valid = !fifo_empty;
   assign m_addr  = fifo_out[FIFO_W-1 -: ADDR_W];
   assign m_data  = fifo_out[STRB_W +: MEM_DATA_W];
   assign m_strb  = fifo_out[STRB_W-1:0];

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_xyolo_wr_pack.sv
// Directed and randomized checks of the write-back packer with 16-bit
// elements packed four to a 64-bit memory word.
module tb_xyolo_wr_pack;

   typedef struct packed {
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic [31:0] base_addr = '0;
   logic [19:0] n_elems = '0;
   logic        busy, done, ovf;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_addr;
   logic [63:0] m_data;
   logic [7:0]  m_strb;

   int          n_assert = 0;
   int          n_fail = 0;
   int          ready_mode = 0;   // 0 always ready, 1 random, 2 held low
   int          done_cnt = 0;
   int          stab_err = 0;
   logic        prev_stall = 1'b0;
   wr_t         prev_w;
   wr_t         got_q[$];
   wr_t         exp_q[$];
   logic [15:0] elems[$];

   xyolo_wr_pack #(
      .DATAPATH_W (16),
      .MEM_DATA_W (64),
      .ADDR_W     (32),
      .CNT_W      (20),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .base_addr (base_addr),
      .n_elems   (n_elems),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_addr    (m_addr),
      .m_data    (m_data),
      .m_strb    (m_strb)
   );

   always #5 clk = ~clk;

   // Memory-side ready generator
   always @(negedge clk) begin
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
   end

   // Write-port monitor: collects accepted writes, counts done pulses and
   // flags any change of a stalled request
   always @(posedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (m_valid !== 1'b1 || m_addr !== prev_w.a ||
                            m_data !== prev_w.d || m_strb !== prev_w.s))
            stab_err++;
         if (m_valid && m_ready) got_q.push_back('{m_addr, m_data, m_strb});
         if (done === 1'b1) done_cnt++;
         prev_stall = m_valid && !m_ready;
         prev_w     = '{m_addr, m_data, m_strb};
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [31:0] base, input int n);
      @(negedge clk);
      run = 1'b1; base_addr = base; n_elems = 20'(n);
      @(negedge clk);
      run = 1'b0;
   endtask

   // Offer cnt elements, keeping only those the DUT accepts
   task automatic feed(input int cnt, input bit gaps, input bit seq, input logic [15:0] first);
      int          sent = 0;
      int          guard = 0;
      logic [15:0] nxt = first;
      while (sent < cnt && guard < 3000) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = nxt;
         end
         @(posedge clk);
         if (in_valid && in_ready) begin
            elems.push_back(in_data);
            sent++;
            nxt = seq ? nxt + 16'd1 : 16'($urandom);
         end
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("feed_accepted", 128'(sent), 128'(cnt));
   endtask

   task automatic wait_done(input int budget, output int cycles);
      bit seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(posedge clk);
         cycles++;
         if (done === 1'b1) seen = 1'b1;
      end
      check("done_seen", 128'(seen), 128'(1));
      @(negedge clk);
   endtask

   // Reference: element i goes to word i/4, lane i%4; word w at base+8*w
   task automatic build_exp(input logic [31:0] base);
      int n  = elems.size();
      int nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         wr_t e;
         e.a = base + 32'(8 * w);
         e.d = '0;
         e.s = '0;
         for (int l = 0; l < 4; l++) begin
            if (w * 4 + l < n) begin
               e.d[l*16 +: 16] = elems[w*4 + l];
               e.s[l*2 +: 2]   = 2'b11;
            end
         end
         exp_q.push_back(e);
      end
      elems.delete();
   endtask

   task automatic compare(input string tag);
      check({tag, "_nwrites"}, 128'(got_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         $display("%s write %0d: addr=%08h data=%016h strb=%02h", tag, i,
                  got_q[i].a, got_q[i].d, got_q[i].s);
         check($sformatf("%s_addr%0d", tag, i), 128'(got_q[i].a), 128'(exp_q[i].a));
         check($sformatf("%s_data%0d", tag, i), 128'(got_q[i].d), 128'(exp_q[i].d));
         check($sformatf("%s_strb%0d", tag, i), 128'(got_q[i].s), 128'(exp_q[i].s));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      int d0;
      logic [31:0] rb;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_ovf", 128'(ovf), 128'(0));
      check("rst_m_valid", 128'(m_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_m_fields", {m_addr, m_data, m_strb}, 128'(0));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: two full words, always ready
      ready_mode = 0;
      d0 = done_cnt;
      start(32'h1000, 8);
      check("t1_busy", 128'(busy), 128'(1));
      feed(8, 1'b0, 1'b1, 16'd1);
      wait_done(200, cyc);
      check("t1_word0", 128'(got_q[0].d), 128'(64'h0004_0003_0002_0001));
      check("t1_word1", 128'(got_q[1].d), 128'(64'h0008_0007_0006_0005));
      build_exp(32'h1000);
      compare("t1");
      repeat (2) @(negedge clk);
      check("t1_one_done", 128'(done_cnt - d0), 128'(1));
      check("t1_ovf", 128'(ovf), 128'(0));
      check("t1_idle", 128'(busy), 128'(0));

      // 2: partial final word
      d0 = done_cnt;
      start(32'h2000, 6);
      feed(6, 1'b0, 1'b1, 16'd1);
      wait_done(200, cyc);
      check("t2_addr1", 128'(got_q[1].a), 128'(32'h2008));
      check("t2_data1", 128'(got_q[1].d), 128'(64'h0000_0000_0006_0005));
      check("t2_strb1", 128'(got_q[1].s), 128'(8'h0F));
      build_exp(32'h2000);
      compare("t2");
      check("t2_one_done", 128'(done_cnt - d0), 128'(1));

      // 3: back-pressure fills the FIFO, extra element overflows
      ready_mode = 2;
      d0 = done_cnt;
      start(32'h6000, 20);
      feed(16, 1'b0, 1'b0, 16'h1234);
      check("t3_in_ready_full", 128'(in_ready), 128'(0));
      check("t3_m_valid", 128'(m_valid), 128'(1));
      check("t3_ovf_before", 128'(ovf), 128'(0));
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      @(negedge clk);
      in_valid = 1'b0;
      check("t3_ovf_set", 128'(ovf), 128'(1));
      repeat (3) @(negedge clk);
      check("t3_head_addr", 128'(m_addr), 128'(32'h6000));
      ready_mode = 0;
      feed(4, 1'b0, 1'b0, 16'h4321);
      wait_done(300, cyc);
      build_exp(32'h6000);
      compare("t3");
      check("t3_one_done", 128'(done_cnt - d0), 128'(1));
      check("t3_ovf_sticky", 128'(ovf), 128'(1));

      // 4: empty run, then run pulsed while busy
      d0 = done_cnt;
      start(32'h5000, 0);
      check("t4_ovf_cleared", 128'(ovf), 128'(0));
      wait_done(20, cyc);
      check("t4_done_latency", 128'(cyc), 128'(2));
      check("t4_no_writes", 128'(got_q.size()), 128'(0));
      check("t4_one_done", 128'(done_cnt - d0), 128'(1));
      d0 = done_cnt;
      start(32'h3000, 4);
      start(32'h9000, 0);
      feed(4, 1'b1, 1'b0, 16'h0);
      wait_done(200, cyc);
      build_exp(32'h3000);
      compare("t4");
      check("t4b_one_done", 128'(done_cnt - d0), 128'(1));

      // 5: reset while draining two stalled words
      ready_mode = 2;
      d0 = done_cnt;
      start(32'h7000, 8);
      feed(8, 1'b0, 1'b0, 16'h0);
      repeat (2) @(negedge clk);
      check("t5_pending", 128'(m_valid), 128'(1));
      rst = 1'b0;
      #1;
      check("t5_rst_flags", {busy, done, ovf, m_valid, in_ready}, 128'(0));
      check("t5_rst_m_fields", {m_addr, m_data, m_strb}, 128'(0));
      @(negedge clk);
      rst = 1'b1;
      ready_mode = 0;
      elems.delete();
      repeat (5) @(negedge clk);
      check("t5_no_done", 128'(done_cnt - d0), 128'(0));
      check("t5_no_writes", 128'(got_q.size()), 128'(0));
      start(32'h40, 4);
      feed(4, 1'b0, 1'b0, 16'h0);
      wait_done(200, cyc);
      build_exp(32'h40);
      compare("t5");

      // 6: address wrap
      start(32'hFFFF_FFF8, 8);
      feed(8, 1'b0, 1'b0, 16'h0);
      wait_done(200, cyc);
      check("t6_wrap_addr", 128'(got_q[1].a), 128'(32'h0));
      build_exp(32'hFFFF_FFF8);
      compare("t6");

      // Randomized runs with gaps and random back-pressure
      ready_mode = 1;
      for (int r = 0; r < 5; r++) begin
         int n = $urandom_range(1, 25);
         rb = $urandom;
         d0 = done_cnt;
         start(rb, n);
         feed(n, 1'b1, 1'b0, 16'($urandom));
         wait_done(500, cyc);
         build_exp(rb);
         compare($sformatf("rnd%0d", r));
         check($sformatf("rnd%0d_one_done", r), 128'(done_cnt - d0), 128'(1));
      end

      check("stall_stable", 128'(stab_err), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
